// File: rtl/kypd_move_ctrl.sv
// Debounces keypad codes into one-shot Connect-4 move requests (req/ack) and a pop-mode arm toggle.
// A key is accepted STABLE_CYCLES edges after it is first seen; a release must be equally stable before the next press.
module kypd_move_ctrl #(
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int NUM_COLS      = 7,
    parameter int ACK_TIMEOUT   = 0,
    parameter int CNT_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       move_ack,
    output logic       move_req,
    output logic [2:0] move_col,
    output logic       move_pop,
    output logic       pop_armed,
    output logic       busy,
    output logic       err_pulse
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, REQ, RELEASE} state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [3:0]       MAX_COL_CODE = 4'(NUM_COLS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       code_q, code_nxt;

    logic       req_nxt, pop_nxt, armed_nxt, err_nxt, busy_nxt;
    logic [2:0] col_nxt;

    logic stable_hit, accept, ack_hit, timeout, is_move, is_pop_key;

    assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign stable_hit = key_valid && (key_code == code_q);
    assign is_move    = (code_q != 4'h0) && (code_q <= MAX_COL_CODE);
    assign is_pop_key = (code_q == 4'hA);
    assign accept     = (state == DEBOUNCE) && stable_hit && (cnt == STABLE_LAST);
    assign ack_hit    = (state == REQ) && move_ack;
    // Ack on the same edge as the timeout wins, so timeout requires no ack.
    assign timeout    = (state == REQ) && !move_ack && (ACK_TIMEOUT != 0) && (cnt == ACK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            code_q    <= 4'h0;
            move_req  <= 1'b0;
            move_col  <= 3'd0;
            move_pop  <= 1'b0;
            pop_armed <= 1'b0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            code_q    <= code_nxt;
            move_req  <= req_nxt;
            move_col  <= col_nxt;
            move_pop  <= pop_nxt;
            pop_armed <= armed_nxt;
            busy      <= busy_nxt;
            err_pulse <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    code_nxt  = key_code;
                    cnt_nxt   = '0;
                    state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!stable_hit) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (accept) begin
                    cnt_nxt   = '0;
                    state_nxt = is_move ? REQ : RELEASE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            REQ: begin
                if (ack_hit || timeout) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RELEASE: begin
                // Any held key restarts the release window; codes seen here are discarded.
                if (key_valid) begin
                    cnt_nxt = '0;
                end else if (cnt == STABLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        req_nxt   = move_req;
        col_nxt   = move_col;
        pop_nxt   = move_pop;
        armed_nxt = pop_armed;
        err_nxt   = 1'b0;
        busy_nxt  = (state_nxt != IDLE);
        if (accept) begin
            if (is_move) begin
                req_nxt = 1'b1;
                col_nxt = code_q[2:0] - 3'd1;
                pop_nxt = pop_armed;
            end else if (is_pop_key) begin
                armed_nxt = ~pop_armed;
            end else begin
                err_nxt = 1'b1;
            end
        end
        if (ack_hit) begin
            req_nxt   = 1'b0;
            armed_nxt = 1'b0;
        end
        if (timeout) begin
            req_nxt = 1'b0;
            err_nxt = 1'b1;
        end
    end

endmodule
